// File: rtl/mux_lut_gate_array.sv
// Two-stage, valid/ready, bitwise two-input function unit. Each result bit is a
// 4:1 mux: the operand bits are the selects and a loadable truth table is the data.

module mux_lut_lane (
  input  logic [3:0] tt,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       y_bit
);
  assign y_bit = tt[{a_bit, b_bit}];
endmodule

module mux_lut_gate_array #(
  parameter int           WIDTH      = 8,
  parameter logic [3:0]   DEFAULT_TT = 4'b1000,
  parameter int           CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  output logic [3:0]       tt_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [3:0]       s1_tt;
  logic [WIDTH-1:0] lane_y;
  logic             s2_load, accept;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  // Every lane reads the table snapshot taken when its operand was accepted.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      mux_lut_lane u_lane (
        .tt    (s1_tt),
        .a_bit (s1_a[i]),
        .b_bit (s1_b[i]),
        .y_bit (lane_y[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt_q      <= DEFAULT_TT;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tt     <= DEFAULT_TT;
      out_valid <= 1'b0;
      y         <= '0;
      op_count  <= '0;
    end else begin
      if (cfg_we) tt_q <= cfg_tt;

      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_tt    <= tt_q;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) y <= lane_y;
      end

      if (out_valid && out_ready) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/mux_lut_gate_array.md
# mux_lut_gate_array

Parametrised, pipelined successor to the mux-built AND/OR gate pair. It computes any of the 16 two-input Boolean functions bitwise across WIDTH-bit operands. Each bit is a 4:1 mux: the operand bits drive the select lines and a run-time-loadable 4-bit truth table drives the data inputs. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides and a completed-operation counter for bring-up.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥1).
- DEFAULT_TT, 4'b1000, truth table loaded at reset (4'b1000 = AND).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- cfg_we  input  1  truth-table write strobe.
- cfg_tt  input  4  new truth table. Bit index = {a_bit,b_bit}: tt[0] is the result for a=0,b=0 and tt[3] for a=1,b=1.
- tt_q  output  4  currently active truth table.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result; y[i] = tt_snapshot[{a[i],b[i]}].
- op_count  output  CNT_W  number of completed output handshakes.

## Operation
- Reset (rst_n=0 at a rising edge) sets:
  - tt_q=DEFAULT_TT, both stage valids=0, out_valid=0, y=0, op_count=0.
  - in_ready is 1 from the first cycle after reset deasserts.
  - A reset in mid-operation discards all in-flight operands without producing an output.
- Pipeline stages:
  - Stage 1 (S1) registers a, b and a snapshot of tt_q. It accepts when in_valid && in_ready.
  - Stage 2 (S2) computes the per-bit mux from the S1 registers and registers the result into y and out_valid.
- Flow control:
  - S2 can load when !out_valid || out_ready.
  - S1 advances into S2 whenever S2 can load.
  - in_ready = !s1_valid || S2 can load. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - When neither stage moves, both hold their data, and y stays stable while out_valid && !out_ready.
- Truth-table write:
  - cfg_we=1 loads cfg_tt into tt_q at the clock edge.
  - An operand accepted in the same cycle as cfg_we captures the OLD tt_q.
  - Operands accepted on later cycles use the new table.
  - In-flight operations keep their snapshot.
  - A write never stalls the handshake.
- op_count increments by 1 on every cycle with out_valid && out_ready and wraps from 2^CNT_W−1 to 0.
- Reference encodings:
  - AND 4'b1000, OR 4'b1110, XOR 4'b0110, NAND 4'b0111, NOR 4'b0001, XNOR 4'b1001.
  - A-passthrough 4'b1100, constant 0 4'b0000, constant 1 4'b1111.

## Timing
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+1, valid in cycle N+1 → N+2.
- Throughput: one operation per cycle with out_ready held high. The two stages give 2 entries of buffering, so no bubbles appear on the input side.
- Backpressure:
  - With out_ready=0, S2 holds and S1 fills, after which in_ready=0.
  - When out_ready returns to 1, in_ready=1 in the same cycle.
- Simultaneous accept and drain with both stages full: S2 takes S1, S1 takes the new operand, and nothing is lost or duplicated.
- tt_q reflects a write the cycle after the cfg_we edge.

## Test plan
- Reset, then AND: after reset tt_q=4'b1000, op_count=0, out_valid=0. Drive a=8'hF0, b=8'hCC with out_ready=1 → y=8'hC0, 2 cycles after acceptance; op_count=1.
- Table sweep: back-to-back operands a=8'hF0, b=8'hCC under OR (4'b1110), XOR (4'b0110) and NAND (4'b0111), with each table loaded one cycle before its operand → y=8'hFC, 8'h3C, 8'h3F. Expect one result per cycle with no bubbles.
- Same-cycle write: tt=AND, then assert cfg_we (cfg_tt=4'b1110) together with an accepted operand a=8'hAA, b=8'h55 → y=8'h00 (old AND). The next operand with the same values → y=8'hFF.
- Backpressure: hold out_ready=0 and stream 3 operands → in_ready drops after 2 accepts, and y holds the first result stable. Release out_ready → results are delivered in order with none lost, and op_count=3.
- Reset mid-flight: 2 operations in the pipe, pull rst_n low for 1 cycle → out_valid=0, y=0, tt_q=DEFAULT_TT, op_count=0, and no stale result appears afterwards.
- Counter wrap: with CNT_W=4, complete 17 handshakes → op_count=1.
